// File: rtl/plic_gateway_pkg.sv
// Shared definitions for the PLIC interrupt gateway: default sizing and per-source state encoding.
// The PLIC_GW_EDGE_CNT_EN build option is consumed by plic_gateway and plic_gw_src.
package plic_gateway_pkg;

    localparam int unsigned PlicNumSrc = 6;
    localparam int unsigned PlicIdW    = 3;
    localparam int unsigned PlicCntW   = 2;

    typedef enum logic [1:0] {
        GwIdle = 2'b00,
        GwPend = 2'b01,
        GwServ = 2'b10
    } gw_state_e;

endpackage

// File: rtl/plic_gateway_if.sv
// Gateway-side bundle: raw interrupt lines, PLIC claim/complete strobes and per-source status.
// Signal suffixes are from the gateway's point of view (slave modport).
interface plic_gateway_if #(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned ID_W    = 3
);
    logic [NUM_SRC-1:0] irq_src_i;
    logic [NUM_SRC-1:0] trig_edge_i;
    logic               claim_i;
    logic [ID_W-1:0]    claim_id_i;
    logic               complete_i;
    logic [ID_W-1:0]    complete_id_i;
    logic [NUM_SRC-1:0] pending_o;
    logic [NUM_SRC-1:0] in_service_o;
    logic [NUM_SRC-1:0] dropped_o;

    modport master (
        output irq_src_i,
        output trig_edge_i,
        output claim_i,
        output claim_id_i,
        output complete_i,
        output complete_id_i,
        input  pending_o,
        input  in_service_o,
        input  dropped_o
    );

    modport slave (
        input  irq_src_i,
        input  trig_edge_i,
        input  claim_i,
        input  claim_id_i,
        input  complete_i,
        input  complete_id_i,
        output pending_o,
        output in_service_o,
        output dropped_o
    );

endinterface

// File: rtl/plic_gw_src.sv
// One gateway source: 2-flop synchroniser, edge detect, IDLE/PENDING/SERVICE handshake and rearm.
// With PLIC_GW_EDGE_CNT_EN defined, edges seen while PENDING also count toward rearm.
module plic_gw_src
    import plic_gateway_pkg::*;
#(
    parameter int unsigned ID      = 1,
    parameter int unsigned ID_W    = 3,
    parameter int unsigned REARM_W = 1
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            irq_i,
    input  logic            trig_edge_i,
    input  logic            claim_i,
    input  logic [ID_W-1:0] claim_id_i,
    input  logic            complete_i,
    input  logic [ID_W-1:0] complete_id_i,
    output logic            pending_o,
    output logic            in_service_o,
    output logic            dropped_o
);

    localparam logic [ID_W-1:0]    OwnId    = ID_W'(ID);
    localparam logic [REARM_W-1:0] RearmMax = {REARM_W{1'b1}};

    logic s1_q, s2_q, prev_q;

    gw_state_e          state_q;
    logic [REARM_W-1:0] rearm_q;
    logic [REARM_W-1:0] rearm_inc;
    logic               pending_q, in_service_q, dropped_q;

    logic rise, req, edge_evt, count_edge, drop;
    logic claim_hit, complete_hit;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= irq_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // prev resets low, so a line already high at reset release yields one rise.
    assign rise     = s2_q & ~prev_q;
    assign req      = trig_edge_i ? rise : s2_q;
    assign edge_evt = trig_edge_i & rise;

    // Out-of-range IDs can never equal OwnId, so they fall out naturally.
    assign claim_hit    = claim_i && (claim_id_i == OwnId);
    assign complete_hit = complete_i && (complete_id_i == OwnId);

`ifdef PLIC_GW_EDGE_CNT_EN
    assign count_edge = edge_evt & ((state_q == GwServ) | (state_q == GwPend));
`else
    assign count_edge = edge_evt & (state_q == GwServ);
`endif

    always_comb begin
        rearm_inc = rearm_q;
        drop      = 1'b0;
        if (count_edge) begin
            if (rearm_q == RearmMax) begin
                drop = 1'b1;
            end else begin
                rearm_inc = rearm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= GwIdle;
            rearm_q      <= '0;
            pending_q    <= 1'b0;
            in_service_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            dropped_q <= drop;
            rearm_q   <= rearm_inc;
            unique case (state_q)
                GwIdle: begin
                    if (req) begin
                        state_q   <= GwPend;
                        pending_q <= 1'b1;
                    end
                end
                GwPend: begin
                    if (claim_hit) begin
                        state_q      <= GwServ;
                        pending_q    <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                GwServ: begin
                    // An edge in this same cycle is already folded into rearm_inc.
                    if (complete_hit) begin
                        in_service_q <= 1'b0;
                        if (rearm_inc != '0) begin
                            state_q   <= GwPend;
                            pending_q <= 1'b1;
                            rearm_q   <= rearm_inc - 1'b1;
                        end else begin
                            state_q <= GwIdle;
                        end
                    end
                end
                default: begin
                    state_q      <= GwIdle;
                    pending_q    <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o    = pending_q;
    assign in_service_o = in_service_q;
    assign dropped_o    = dropped_q;

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: NUM_SRC independent plic_gw_src slices, source k+1 on bit k.
// Define PLIC_GW_EDGE_CNT_EN to widen the per-source rearm flag into a CNT_W-bit counter.
module plic_gateway
    import plic_gateway_pkg::*;
#(
    parameter int unsigned NUM_SRC = PlicNumSrc,
    parameter int unsigned ID_W    = PlicIdW,
    parameter int unsigned CNT_W   = PlicCntW
) (
    input  logic           wb_clk_i,
    input  logic           wb_rst_i,
    plic_gateway_if.slave  gw
);

`ifdef PLIC_GW_EDGE_CNT_EN
    localparam int unsigned RearmW = CNT_W;
`else
    localparam int unsigned RearmW = 1;
`endif

    // ID 0 is reserved, so every source ID must fit beside it.
    if ((1 << ID_W) <= NUM_SRC) begin : g_bad_id_w
        $error("plic_gateway: ID_W too narrow for NUM_SRC");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("plic_gateway: CNT_W must be at least 1");
    end

    logic [NUM_SRC-1:0] pend_vec;
    logic [NUM_SRC-1:0] serv_vec;
    logic [NUM_SRC-1:0] drop_vec;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        plic_gw_src #(
            .ID      (k + 1),
            .ID_W    (ID_W),
            .REARM_W (RearmW)
        ) u_src (
            .wb_clk_i      (wb_clk_i),
            .wb_rst_i      (wb_rst_i),
            .irq_i         (gw.irq_src_i[k]),
            .trig_edge_i   (gw.trig_edge_i[k]),
            .claim_i       (gw.claim_i),
            .claim_id_i    (gw.claim_id_i),
            .complete_i    (gw.complete_i),
            .complete_id_i (gw.complete_id_i),
            .pending_o     (pend_vec[k]),
            .in_service_o  (serv_vec[k]),
            .dropped_o     (drop_vec[k])
        );
    end

    assign gw.pending_o    = pend_vec;
    assign gw.in_service_o = serv_vec;
    assign gw.dropped_o    = drop_vec;

endmodule

// File: tb/tb_plic_gateway.sv
// Directed bench for plic_gateway: a per-source pending/service/rearm model checked every cycle,
// plus hand-computed literal checkpoints. Counter section runs only with PLIC_GW_EDGE_CNT_EN.
module tb_plic_gateway;

    localparam int NS = 6;
    localparam int IW = 3;
    localparam int CW = 2;
`ifdef PLIC_GW_EDGE_CNT_EN
    localparam int  RMax    = (1 << CW) - 1;
    localparam bit  CntPend = 1'b1;
    localparam int  ExpDrop = 0;
`else
    localparam int  RMax    = 1;
    localparam bit  CntPend = 1'b0;
    localparam int  ExpDrop = 1;
`endif

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    plic_gateway_if #(.NUM_SRC(NS), .ID_W(IW)) gw_if ();

    plic_gateway #(.NUM_SRC(NS), .ID_W(IW), .CNT_W(CW)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .gw       (gw_if)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Model: delayed copies of the raw lines plus pending/service bits and rearm counts.
    logic [NS-1:0] h1, h2, h3;
    logic [NS-1:0] m_pend, m_serv, m_drop;
    int            m_cnt [NS];

    int n_tests   = 0;
    int n_fail    = 0;
    int drop_seen = 0;

    task automatic check(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        h1 = '0; h2 = '0; h3 = '0;
        m_pend = '0; m_serv = '0; m_drop = '0;
        for (int k = 0; k < NS; k++) m_cnt[k] = 0;
    endtask

    task automatic bump(input int k);
        if (m_cnt[k] == RMax) m_drop[k] = 1'b1;
        else m_cnt[k] = m_cnt[k] + 1;
    endtask

    task automatic model_step();
        for (int k = 0; k < NS; k++) begin
            automatic bit rise = h2[k] & ~h3[k];
            automatic bit edg  = gw_if.trig_edge_i[k] & rise;
            automatic bit req  = gw_if.trig_edge_i[k] ? rise : h2[k];
            automatic bit ch   = gw_if.claim_i && (int'(gw_if.claim_id_i) == k + 1);
            automatic bit dh   = gw_if.complete_i && (int'(gw_if.complete_id_i) == k + 1);
            m_drop[k] = 1'b0;
            if (m_serv[k]) begin
                if (edg) bump(k);
                if (dh) begin
                    m_serv[k] = 1'b0;
                    if (m_cnt[k] > 0) begin
                        m_pend[k] = 1'b1;
                        m_cnt[k]  = m_cnt[k] - 1;
                    end
                end
            end else if (m_pend[k]) begin
                if (edg && CntPend) bump(k);
                if (ch) begin
                    m_pend[k] = 1'b0;
                    m_serv[k] = 1'b1;
                end
            end else if (req) begin
                m_pend[k] = 1'b1;
            end
        end
        h3 = h2;
        h2 = h1;
        h1 = gw_if.irq_src_i;
    endtask

    // Advance one clock: model sees the same inputs as the DUT edge, outputs compared on the negedge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk_i);
            if (!wb_rst_i) model_step();
            @(negedge wb_clk_i);
            check("pending_o", gw_if.pending_o, m_pend);
            check("in_service_o", gw_if.in_service_o, m_serv);
            check("dropped_o", gw_if.dropped_o, m_drop);
            drop_seen += $countones(gw_if.dropped_o);
        end
    endtask

    task automatic strobe_claim(input int id);
        gw_if.claim_i    = 1'b1;
        gw_if.claim_id_i = IW'(id);
        tick();
        gw_if.claim_i    = 1'b0;
    endtask

    task automatic strobe_complete(input int id);
        gw_if.complete_i    = 1'b1;
        gw_if.complete_id_i = IW'(id);
        tick();
        gw_if.complete_i    = 1'b0;
    endtask

    task automatic pulse(input int k);
        gw_if.irq_src_i[k] = 1'b1;
        tick(2);
        gw_if.irq_src_i[k] = 1'b0;
        tick(2);
    endtask

    // Assert reset away from any clock edge; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("rst pending", gw_if.pending_o, 6'b000000);
        check("rst in_service", gw_if.in_service_o, 6'b000000);
        check("rst dropped", gw_if.dropped_o, 6'b000000);
        model_reset();
        tick(2);
        wb_rst_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        gw_if.irq_src_i     = '0;
        gw_if.trig_edge_i   = '0;
        gw_if.claim_i       = 1'b0;
        gw_if.claim_id_i    = '0;
        gw_if.complete_i    = 1'b0;
        gw_if.complete_id_i = '0;
        model_reset();
        #2;
        check("reset pending", gw_if.pending_o, 6'b000000);
        check("reset in_service", gw_if.in_service_o, 6'b000000);
        check("reset dropped", gw_if.dropped_o, 6'b000000);
        tick(2);
        wb_rst_i = 1'b0;

        // Level source 1: three clocks to pending, claim, complete with line still high.
        gw_if.irq_src_i[0] = 1'b1;
        tick(2);
        check("lvl latency 2clk", gw_if.pending_o, 6'b000000);
        tick();
        check("lvl pending 3clk", gw_if.pending_o, 6'b000001);
        strobe_claim(1);
        check("claim1 pending", gw_if.pending_o, 6'b000000);
        check("claim1 in_service", gw_if.in_service_o, 6'b000001);
        strobe_complete(1);
        check("complete1 in_service", gw_if.in_service_o, 6'b000000);
        check("complete1 pending+1", gw_if.pending_o, 6'b000000);
        tick();
        check("complete1 pending+2", gw_if.pending_o, 6'b000001);
        gw_if.irq_src_i[0] = 1'b0;
        tick(4);
        check("lvl no retraction", gw_if.pending_o, 6'b000001);

        // Edge source 2: first pulse latches, second while PENDING is coalesced.
        gw_if.trig_edge_i[1] = 1'b1;
        gw_if.irq_src_i[1]   = 1'b1;
        tick(4);
        gw_if.irq_src_i[1]   = 1'b0;
        tick(3);
        check("edge pending", gw_if.pending_o, 6'b000011);
        drop_seen = 0;
        gw_if.irq_src_i[1] = 1'b1;
        tick(3);
        gw_if.irq_src_i[1] = 1'b0;
        tick(4);
        check("edge coalesced", gw_if.pending_o, 6'b000011);
        check("edge no drop", 6'(drop_seen), 6'd0);

        // Two edges during SERVICE: the second overflows the rearm flag.
        strobe_claim(2);
        check("claim2 in_service", gw_if.in_service_o, 6'b000010);
        check("claim2 pending", gw_if.pending_o, 6'b000001);
        drop_seen = 0;
        pulse(1);
        pulse(1);
        tick(3);
        check("serv drop count", 6'(drop_seen), 6'(ExpDrop));
        strobe_complete(2);
        check("rearm repend", gw_if.pending_o, 6'b000011);
        check("rearm in_service", gw_if.in_service_o, 6'b000000);

        do_reset();

        // Bad IDs and strobes aimed at the wrong state change nothing.
        gw_if.trig_edge_i = 6'b000010;
        gw_if.irq_src_i   = 6'b000011;
        tick(3);
        gw_if.irq_src_i[1] = 1'b0;
        check("setup pending", gw_if.pending_o, 6'b000011);
        strobe_claim(0);
        strobe_claim(7);
        strobe_claim(3);
        strobe_complete(3);
        strobe_complete(1);
        strobe_complete(0);
        tick();
        check("bad id pending", gw_if.pending_o, 6'b000011);
        check("bad id in_service", gw_if.in_service_o, 6'b000000);
        gw_if.irq_src_i[0] = 1'b0;

        // Complete ID1 and claim ID2 together, then same-ID claim+complete.
        strobe_claim(1);
        check("sim claim1", gw_if.in_service_o, 6'b000001);
        gw_if.claim_i       = 1'b1;
        gw_if.claim_id_i    = 3'd2;
        gw_if.complete_i    = 1'b1;
        gw_if.complete_id_i = 3'd1;
        tick();
        check("sim in_service", gw_if.in_service_o, 6'b000010);
        check("sim pending", gw_if.pending_o, 6'b000000);
        gw_if.complete_id_i = 3'd2;
        tick();
        gw_if.claim_i    = 1'b0;
        gw_if.complete_i = 1'b0;
        check("same id in_service", gw_if.in_service_o, 6'b000000);
        check("same id pending", gw_if.pending_o, 6'b000000);

        // Edge landing on the same clock as complete re-pends the source.
        pulse(1);
        strobe_claim(2);
        tick(2);
        gw_if.irq_src_i[1] = 1'b1;
        tick(2);
        strobe_complete(2);
        check("cmpl+edge pending", gw_if.pending_o, 6'b000010);
        check("cmpl+edge in_service", gw_if.in_service_o, 6'b000000);
        gw_if.irq_src_i[1] = 1'b0;
        tick(3);

        // Reset in SERVICE with an edge line held high: one rise registers after release.
        strobe_claim(2);
        check("pre-reset in_service", gw_if.in_service_o, 6'b000010);
        gw_if.irq_src_i[1] = 1'b1;
        do_reset();
        tick(3);
        check("post-reset rise", gw_if.pending_o, 6'b000010);
        gw_if.irq_src_i[1] = 1'b0;
        tick(2);

`ifdef PLIC_GW_EDGE_CNT_EN
        do_reset();
        gw_if.trig_edge_i = 6'b000100;
        pulse(2);
        strobe_claim(3);
        drop_seen = 0;
        for (int p = 0; p < 4; p++) pulse(2);
        tick(3);
        check("cnt drop count", 6'(drop_seen), 6'd1);
        for (int c = 0; c < 3; c++) begin
            strobe_complete(3);
            check("cnt repend", gw_if.pending_o, 6'b000100);
            strobe_claim(3);
        end
        strobe_complete(3);
        check("cnt drained pending", gw_if.pending_o, 6'b000000);
        check("cnt drained in_service", gw_if.in_service_o, 6'b000000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
